regfile_wb_sched: RTL
=====================

# regfile_wb_sched

Write-back scheduler and scoreboard for the 32x32 register file, which has one write port. It arbitrates the single write port between the ALU and LSU write-back sources. It also tracks which architectural registers have a write outstanding, and stalls instruction issue on RAW/WAW hazards. The block sits between the execute/memory stages and the register file's AddrD/DataD/RegWEn port; the register file commits on negedge clk.

## Interface
Parameters:
- XLEN, 32, data width of write-back payload and DataD.
- NREG, 32, architectural register count; register 0 is hardwired zero.

Ports:
- clk  input  1  system clock; all state updates on posedge.
- rst_n  input  1  asynchronous active-low reset.
- iss_valid  input  1  an instruction is presented for issue.
- iss_rd  input  5  destination register of issuing instruction.
- iss_rs1, iss_rs2  input  5 each  source registers.
- iss_use_rs1, iss_use_rs2  input  1 each  source operand actually read.
- iss_stall  output  1  issue blocked this cycle (combinational).
- alu_valid, lsu_valid  input  1 each  write-back request from ALU / LSU.
- alu_rd, lsu_rd  input  5 each  write-back destination.
- alu_data, lsu_data  input  XLEN each  write-back value.
- alu_ready, lsu_ready  output  1 each  grant; handshake completes when valid & ready (combinational).
- RegWEn  output  1  register-file write enable (registered).
- AddrD  output  5  register-file write address (registered).
- DataD  output  XLEN  register-file write data (registered).
- busy  output  NREG  scoreboard vector; bit 0 always 0.
- busy_cnt  output  6  number of set busy bits.
- wb_err  output  1  sticky: write-back to a non-busy nonzero register.

## Operation
- Issue accepted when iss_valid & !iss_stall; an accepted issue with iss_rd != 0 sets busy[iss_rd] at the next posedge.
- iss_stall = iss_valid & ((iss_use_rs1 & busy[iss_rs1]) | (iss_use_rs2 & busy[iss_rs2]) | (iss_rd != 0 & busy[iss_rd])).
- Register 0 is never marked busy, so it never stalls.
- Arbitration uses round-robin with a one-bit preference pointer (reset: prefer ALU).
  - Only one source valid: that source is granted.
  - Both sources valid: the preferred source is granted, and the pointer flips to the other source.
  - A grant without contention leaves the pointer unchanged.
  - At most one ready is high per cycle; ready never depends on busy.
- Write stage: a granted request is registered into AddrD/DataD.
  - RegWEn=1 iff the granted rd != 0.
  - With no grant, RegWEn=0; AddrD/DataD hold their values.
- Clear: in any cycle where RegWEn=1, busy[AddrD] clears at the posedge ending that cycle.
- wb_err sets at that posedge if busy[AddrD] was already 0. It is cleared only by reset.
- Simultaneous set and clear of the same bit cannot occur, because the WAW stall blocks it; the bench must assert this never happens.
- busy_cnt changes at each posedge:
  - +1 on set only.
  - -1 on clear only.
  - Unchanged on both or neither.
  - Saturation is impossible (max 31).
- Reset: busy=0, busy_cnt=0, RegWEn=0, AddrD=0, DataD=0, wb_err=0, pointer=ALU.
  - Reset mid-operation drops any registered write; it is not replayed.

## Timing
- Write-back handshake in cycle N → RegWEn/AddrD/DataD valid throughout cycle N+1.
- The register file commits at negedge of cycle N+1.
- busy bit reads 0 from cycle N+2; a stalled dependent issues in cycle N+2. Write-back-to-issue latency is 2 cycles.
- Issue in cycle M → busy[rd]=1 from cycle M+1; a dependent in M+1 stalls.
- Throughput: one write per cycle sustained; the write stage never backpressures.
- iss_stall, alu_ready and lsu_ready are combinational from current inputs and registered state; no combinational path runs from ready to valid.

## Test plan
- Reset: assert rst_n=0 mid-stream with RegWEn=1 → all outputs are 0 immediately (asynchronous); after release, busy=0 and the ALU is preferred.
- RAW:
  - Issue rd=5, then next cycle issue rs1=5 → stall.
  - ALU write-back rd=5 data=0xDEADBEEF in cycle N → RegWEn=1, AddrD=5 in N+1; stall drops in N+2; busy_cnt goes 1→0.
- Contention: alu_valid=lsu_valid=1 for 4 cycles → grants alternate ALU, LSU, ALU, LSU; AddrD follows the granted rd each following cycle.
- WAW/zero:
  - busy[7]=1, issue rd=7 → stall.
  - Issue rd=0 with rs1=0 → no stall and busy unchanged.
  - Write-back rd=0 → ready=1 and RegWEn=0.
- Error: write-back rd=9 while busy[9]=0 → write is performed (RegWEn=1, AddrD=9); wb_err=1 from the next cycle and stays set.
- Back-to-back: issue rd=3 and rd=4 on consecutive cycles, then LSU write-back rd=4 and ALU write-back rd=3 → busy_cnt 0,1,2,1,0 and no err.

Source files
------------

// File: rtl/regfile_wb_sched.sv
// Purpose: arbitrates the register-file write port between ALU and LSU, and keeps the busy scoreboard that stalls issue.
// Latency: a grant in cycle N drives RegWEn/AddrD/DataD in N+1, and the busy bit reads clear from N+2.
// Backpressure: iss_stall on RAW/WAW hazards; the source that loses arbitration waits (round-robin); the write stage never stalls.
module regfile_wb_sched #(
  parameter int XLEN = 32,
  parameter int NREG = 32
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic            iss_valid,
  input  logic [4:0]      iss_rd,
  input  logic [4:0]      iss_rs1,
  input  logic [4:0]      iss_rs2,
  input  logic            iss_use_rs1,
  input  logic            iss_use_rs2,
  output logic            iss_stall,
  input  logic            alu_valid,
  input  logic [4:0]      alu_rd,
  input  logic [XLEN-1:0] alu_data,
  output logic            alu_ready,
  input  logic            lsu_valid,
  input  logic [4:0]      lsu_rd,
  input  logic [XLEN-1:0] lsu_data,
  output logic            lsu_ready,
  output logic            RegWEn,
  output logic [4:0]      AddrD,
  output logic [XLEN-1:0] DataD,
  output logic [NREG-1:0] busy,
  output logic [5:0]      busy_cnt,
  output logic            wb_err
);

  typedef struct packed {
    logic [4:0]      rd;
    logic [XLEN-1:0] data;
  } wb_t;

  logic [NREG-1:0] busy_q;
  logic [NREG-1:0] busy_nxt;
  logic            pref_lsu;
  logic            iss_set;
  logic            clr_eff;
  logic            gnt;
  wb_t             gnt_wb;

  assign busy = busy_q;

  // Hazard detection: stall on a busy source or a busy destination (register 0 is never busy)
  always_comb begin
    iss_stall = iss_valid & ((iss_use_rs1 & busy_q[iss_rs1]) |
                             (iss_use_rs2 & busy_q[iss_rs2]) |
                             ((iss_rd != 5'd0) & busy_q[iss_rd]));
    iss_set   = iss_valid & ~iss_stall & (iss_rd != 5'd0);
  end

  // Round-robin grant: the pointer only matters when both sources request
  always_comb begin
    alu_ready = alu_valid & (~lsu_valid | ~pref_lsu);
    lsu_ready = lsu_valid & (~alu_valid | pref_lsu);
    gnt       = alu_ready | lsu_ready;
    gnt_wb    = lsu_ready ? wb_t'{rd: lsu_rd, data: lsu_data}
                          : wb_t'{rd: alu_rd, data: alu_data};
  end

  // Next scoreboard state: the issue sets a bit and the write stage clears one; bit 0 stays zero
  always_comb begin
    busy_nxt = busy_q;
    if (iss_set) busy_nxt[iss_rd] = 1'b1;
    if (RegWEn)  busy_nxt[AddrD]  = 1'b0;
    busy_nxt[0] = 1'b0;
    // Only a clear that actually drops a set bit lowers the count, so busy_cnt tracks the popcount
    clr_eff = RegWEn & busy_q[AddrD];
  end

  // Arbitration pointer: flips only after a contended grant
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)                       pref_lsu <= 1'b0;
    else if (alu_valid && lsu_valid)  pref_lsu <= ~pref_lsu;
  end

  // Write stage: capture the granted request; with no grant, address and data hold
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      RegWEn <= 1'b0;
      AddrD  <= '0;
      DataD  <= '0;
    end else begin
      RegWEn <= gnt & (gnt_wb.rd != 5'd0);
      if (gnt) begin
        AddrD <= gnt_wb.rd;
        DataD <= gnt_wb.data;
      end
    end
  end

  // Scoreboard, busy count and sticky write-back error
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      busy_q   <= '0;
      busy_cnt <= '0;
      wb_err   <= 1'b0;
    end else begin
      busy_q <= busy_nxt;
      case ({iss_set, clr_eff})
        2'b10:   busy_cnt <= busy_cnt + 6'd1;
        2'b01:   busy_cnt <= busy_cnt - 6'd1;
        default: busy_cnt <= busy_cnt;
      endcase
      if (RegWEn && !busy_q[AddrD]) wb_err <= 1'b1;
    end
  end

endmodule
